// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads a 16-word block, then streams W[0..63]
// out of a sliding 16-word window that computes W[t+16] each time a word leaves.
module sha256_msg_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_word,
    output logic [5:0]  w_idx,
    output logic        w_last,
    output logic        busy
);

    // state | meaning
    // LOAD  | accepting the 16 message words into the window
    // EMIT  | presenting win[0] as W[t] and sliding the window per accepted word
    typedef enum logic {S_LOAD = 1'b0, S_EMIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  load_cnt_q, load_cnt_d;
    logic [5:0]  t_q, t_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [31:0] w_next;
    logic        load_fire;
    logic        emit_fire;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // win[k] holds W[t+k], so the new tail is W[t+16]
    assign w_next    = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
    assign load_fire = (state_q == S_LOAD) && in_valid;
    assign emit_fire = (state_q == S_EMIT) && w_ready;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        t_d        = t_q;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end

        case (state_q)
            S_LOAD: begin
                if (load_fire) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[15] = in_word;
                    if (load_cnt_q == 4'd15) begin
                        load_cnt_d = 4'd0;
                        state_d    = S_EMIT;
                    end else begin
                        load_cnt_d = load_cnt_q + 4'd1;
                    end
                end
            end
            S_EMIT: begin
                if (emit_fire) begin
                    if (t_q == 6'd63) begin
                        t_d     = 6'd0;
                        state_d = S_LOAD;
                    end else begin
                        for (int i = 0; i < 15; i++) begin
                            win_d[i] = win_q[i+1];
                        end
                        win_d[15] = w_next;
                        t_d       = t_q + 6'd1;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            load_cnt_q <= 4'd0;
            t_q        <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            t_q        <= t_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // Outputs are forced quiet while reset is held, independent of register contents
    assign in_ready = rst_n && (state_q == S_LOAD);
    assign w_valid  = rst_n && (state_q == S_EMIT);
    assign busy     = w_valid;
    assign w_word   = rst_n ? win_q[0] : 32'd0;
    assign w_idx    = rst_n ? t_q : 6'd0;
    assign w_last   = w_valid && (t_q == 6'd63);

endmodule
